// File: rtl/elixirchip_es1_spu_pkg.sv
// rtl/elixirchip_es1_spu_pkg.sv - shared SPU op types and width helpers
package elixirchip_es1_spu_pkg;

  typedef enum logic {
    ST_EMPTY,
    ST_FILL
  } spu_pack_state_e;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int spu_cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_pack_delay.sv
// rtl/elixirchip_es1_spu_op_pack_delay.sv - cke-gated output delay pipe for the flag packer
module elixirchip_es1_spu_op_pack_delay #(
  parameter int STAGES = 0,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, cke};
    assign out_data    = in_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      end else if (cke) begin
        pipe[0] <= in_data;
        for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign out_data = pipe[STAGES-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_pack.sv
// rtl/elixirchip_es1_spu_op_pack.sv - bit-serial flag packer; ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN adds m_any
module elixirchip_es1_spu_op_pack
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 36,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter logic  CLEAR_DATA = 1'bx,
  parameter logic  PAD_DATA   = 1'b0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false",
  localparam int   CNT_W      = spu_cnt_bits(DATA_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic             s_data,
  input  logic             s_last,
  input  logic             s_clear,
  input  logic             s_valid,
  output data_t            m_data,
  output logic [CNT_W-1:0] m_count,
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
  output logic             m_any,
`endif
  output logic             m_valid
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end
  if (DATA_BITS < 2) begin : g_bad_bits
    $error("DATA_BITS must be >= 2");
  end
  if ($bits(data_t) != DATA_BITS) begin : g_bad_type
    $error("data_t width must equal DATA_BITS");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("DEVICE must be non-empty");
  end
  if ((SIMULATION != "true" && SIMULATION != "false") ||
      (DEBUG != "true" && DEBUG != "false")) begin : g_bad_mode
    $error("SIMULATION/DEBUG must be \"true\" or \"false\"");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

  spu_pack_state_e  state;
  data_t            acc;
  logic [CNT_W-1:0] cnt;
  data_t            acc_upd;
  data_t            word;
  logic             emit;

  data_t            s1_data;
  logic [CNT_W-1:0] s1_count;
  logic             s1_valid;

  // acc_upd keeps zeros above the new beat; word is the same with pad fill for emission.
  always_comb begin
    acc_upd = '0;
    word    = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (CNT_W'(i) < cnt) begin
        acc_upd[i] = acc[i];
        word[i]    = acc[i];
      end else if (CNT_W'(i) == cnt) begin
        acc_upd[i] = s_data;
        word[i]    = s_data;
      end else begin
        word[i]    = PAD_DATA;
      end
    end
  end

  assign emit = s_valid & (s_last | (state == ST_FILL && cnt == LAST_IDX));

`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
  logic word_any;
  logic s1_any;

  // Pad bits are excluded so a 1'b1 PAD_DATA never raises m_any.
  always_comb begin
    word_any = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (CNT_W'(i) <= cnt) word_any = word_any | acc_upd[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      acc      <= '0;
      cnt      <= '0;
      s1_data  <= '0;
      s1_count <= '0;
      s1_valid <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
      s1_any   <= 1'b0;
`endif
    end else if (cke) begin
      if (s_clear) begin
        state    <= ST_EMPTY;
        acc      <= '0;
        cnt      <= '0;
        s1_data  <= {DATA_BITS{CLEAR_DATA}};
        s1_count <= '0;
        s1_valid <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
        s1_any   <= 1'b0;
`endif
      end else if (emit) begin
        state    <= ST_EMPTY;
        acc      <= '0;
        cnt      <= '0;
        s1_data  <= word;
        s1_count <= cnt + CNT_W'(1);
        s1_valid <= 1'b1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
        s1_any   <= word_any;
`endif
      end else begin
        s1_valid <= 1'b0;
        if (s_valid) begin
          state <= ST_FILL;
          acc   <= acc_upd;
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ELIXIRCHIP_ES1_SPU_OP_PACK_ANY_EN
  localparam int PW = 2 + CNT_W + DATA_BITS;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;
  assign pipe_in = {s1_any, s1_valid, s1_count, s1_data};
  assign {m_any, m_valid, m_count, m_data} = pipe_out;
`else
  localparam int PW = 1 + CNT_W + DATA_BITS;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;
  assign pipe_in = {s1_valid, s1_count, s1_data};
  assign {m_valid, m_count, m_data} = pipe_out;
`endif

  elixirchip_es1_spu_op_pack_delay #(
    .STAGES (LATENCY - 1),
    .WIDTH  (PW)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .in_data  (pipe_in),
    .out_data (pipe_out)
  );

endmodule
